sqm_root_search: RTL and testbench



---
 rtl/sqm_pkg.sv | 24 ++
 rtl/sqm_mod_sub.sv | 22 ++
 rtl/sqm_root_search.sv | 171 +++++++++++++++++
 tb/tb_sqm_root_search.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sqm_pkg.sv
// sqm_pkg: definitions shared by the SQM arithmetic unit and the modular
// square-root search (operand widths, root-search state encoding).
package sqm_pkg;

  localparam int SQM_B_W  = 4;  // root / multiplier operand width
  localparam int SQM_A_W  = 8;  // modulus and residue width
  localparam int SQM_SQ_W = 9;  // running square: (A-1) + 31 <= 285

  // Root-search sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } sqm_root_state_t;

  // Increment that moves b^2 to (b+1)^2, i.e. 2b+1 (at most 31).
  function automatic logic [SQM_SQ_W-1:0] sqm_step_addend(
    input logic [SQM_B_W-1:0] b
  );
    return {{(SQM_SQ_W-SQM_B_W-1){1'b0}}, b, 1'b1};
  endfunction

endpackage

// File: rtl/sqm_mod_sub.sv
// sqm_mod_sub: one step of modular reduction. Subtracts the modulus from
// the running square when the square is not smaller than it, and reports
// whether the subtraction happened.
module sqm_mod_sub
  import sqm_pkg::*;
(
  input  logic [SQM_SQ_W-1:0] sq,
  input  logic [SQM_A_W-1:0]  a,
  output logic                ge,
  output logic [SQM_SQ_W-1:0] diff
);

  logic [SQM_SQ_W-1:0] a_ext;

  // Compare-and-subtract; the result is only used when ge is set.
  always_comb begin
    a_ext = {1'b0, a};
    ge    = (sq >= a_ext);
    diff  = ge ? (sq - a_ext) : sq;
  end

endmodule

// File: rtl/sqm_root_search.sv
// sqm_root_search: sequential modular square-root finder. For a modulus A
// and residue R it scans B = 0..15 looking for B*B mod A == R, keeping the
// square incrementally ((b+1)^2 = b^2 + 2b + 1) and reducing it by repeated
// subtraction of A, so no multiplier or divider is needed.
//
// Optional feature macro: SQM_ROOT_ALLROOTS_EN. When defined, the scan always
// covers every B and root_cnt/root_mask report all roots; when undefined the
// scan stops at the first root and root_cnt/root_mask are tied to zero.
//
// Handshake: start is sampled only in IDLE together with A and R; busy is
// high from the edge after an accepted start until the end of the done
// cycle; done is a one-cycle pulse during which found/root/err (and the
// all-roots results) are valid; those results then hold until the next
// accepted start. start in any other state is ignored.
module sqm_root_search
  import sqm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  R,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [3:0]  root,
  output logic        err,
  output logic [4:0]  root_cnt,
  output logic [15:0] root_mask
);

`ifdef SQM_ROOT_ALLROOTS_EN
  localparam bit STOP_ON_HIT = 1'b0;
`else
  localparam bit STOP_ON_HIT = 1'b1;
`endif

  // Sequencer state; kept as a plain named signal so checkers can bind to it.
  sqm_root_state_t state;

  logic [SQM_A_W-1:0]  a_q;
  logic [SQM_A_W-1:0]  r_q;
  logic [SQM_B_W-1:0]  b_q;
  logic [SQM_SQ_W-1:0] sq_q;
  logic                found_q;
  logic [SQM_B_W-1:0]  root_q;
  logic                err_q;

  logic                sub_ge;
  logic [SQM_SQ_W-1:0] sub_diff;
  logic                hit;
  logic                last_b;
  logic                stop;

  sqm_mod_sub u_mod_sub (
    .sq   (sq_q),
    .a    (a_q),
    .ge   (sub_ge),
    .diff (sub_diff)
  );

  // In CHECK the square is already reduced below A (<= 254), so its low
  // byte is the full residue.
  always_comb begin
    hit    = (sq_q[SQM_A_W-1:0] == r_q);
    last_b = (b_q == {SQM_B_W{1'b1}});
    stop   = last_b || (hit && STOP_ON_HIT);
  end

`ifdef SQM_ROOT_ALLROOTS_EN
  logic [4:0]  cnt_q;
  logic [15:0] mask_q;

  // All-roots bookkeeping: cleared on an accepted start, updated per hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else if (state == IDLE && start) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else if (state == CHECK && hit) begin
      cnt_q          <= cnt_q + 5'd1;
      mask_q[b_q]    <= 1'b1;
    end
  end

  always_comb begin
    root_cnt  = cnt_q;
    root_mask = mask_q;
  end
`else
  // Without the all-roots feature these results carry no information.
  always_comb begin
    root_cnt  = '0;
    root_mask = '0;
  end
`endif

  // Search sequencer: latch operands, walk b with CHECK/REDUCE, report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      sq_q    <= '0;
      found_q <= 1'b0;
      root_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            r_q     <= R;
            b_q     <= '0;
            sq_q    <= '0;
            found_q <= 1'b0;
            root_q  <= '0;
            if (A == '0) begin
              // A zero modulus has no residues; report it without scanning.
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (hit && !found_q) begin
            found_q <= 1'b1;
            root_q  <= b_q;
          end
          if (stop) begin
            state <= DONE;
          end else begin
            sq_q  <= sq_q + sqm_step_addend(b_q);
            b_q   <= b_q + 4'd1;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          // One subtraction per cycle until the square drops below A.
          if (sub_ge) begin
            sq_q <= sub_diff;
          end else begin
            state <= CHECK;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and results decoded from registered state.
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    found = found_q;
    root  = root_q;
    err   = err_q;
  end

endmodule

// File: tb/tb_sqm_root_search.sv
// tb_sqm_root_search: directed-vector bench for sqm_root_search. A table of
// hand-computed searches is applied in a loop; latency is counted in cycles
// from the accepting edge to the done cycle. Hand-written sequences cover
// start while busy / during done, and reset in the middle of a search.
module tb_sqm_root_search;
  import sqm_pkg::*;

`ifdef SQM_ROOT_ALLROOTS_EN
  localparam bit ALL = 1'b1;
`else
  localparam bit ALL = 1'b0;
`endif
  localparam int MAX_LAT = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  r_in = '0;
  logic        busy, done, found, err;
  logic [3:0]  root;
  logic [4:0]  root_cnt;
  logic [15:0] root_mask;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  // Expected {found, root, err, cnt, mask} per issued search.
  logic [26:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  r;
    logic        found;
    logic [3:0]  root;
    logic        err;
    logic [4:0]  cnt;
    logic [15:0] mask;
    int          lat_first;
    int          lat_all;
  } vec_t;

  vec_t vecs[10];

  sqm_root_search dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (a_in),
    .R         (r_in),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .root      (root),
    .err       (err),
    .root_cnt  (root_cnt),
    .root_mask (root_mask)
  );

  // Clock and done-pulse counter (sampled away from the active edge).
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_pulses++;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] r,
                              input logic f, input logic [3:0] rt,
                              input logic e, input logic [4:0] c,
                              input logic [15:0] m, input int l1,
                              input int la);
    vec_t v;
    v.a = a; v.r = r; v.found = f; v.root = rt; v.err = e;
    v.cnt = c; v.mask = m; v.lat_first = l1; v.lat_all = la;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one search and wait for done; lat is the done cycle index
  // (1 = first cycle after the accepting edge).
  task automatic run_search(input logic [7:0] a, input logic [7:0] r,
                            output int lat, output logic busy1);
    @(negedge clk);
    a_in = a; r_in = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy1 = busy;
    while (!done && lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout a=%0d r=%0d waited=%0d", a, r, lat);
    end
  endtask

  task automatic check_result(input string tag, input logic [26:0] e);
    chk({tag, "_found"}, found, e[26]);
    chk({tag, "_root"}, root, e[25:22]);
    chk({tag, "_err"}, err, e[21]);
    chk({tag, "_cnt"}, root_cnt, e[20:16]);
    chk({tag, "_mask"}, root_mask, e[15:0]);
  endtask

  initial begin
    int lat;
    logic b1;
    logic [26:0] e;
    int pulses0;
    int guard;
    string tag;

    vecs[0] = mk(8'd7,   8'd2,   1, 4'd3,  0, 5'd4,  16'h0C18,  9,  64);
    vecs[1] = mk(8'd16,  8'd3,   0, 4'd0,  0, 5'd0,  16'h0000, 46,  46);
    vecs[2] = mk(8'd0,   8'd5,   0, 4'd0,  1, 5'd0,  16'h0000,  1,   1);
    vecs[3] = mk(8'd1,   8'd0,   1, 4'd0,  0, 5'd16, 16'hFFFF,  2, 257);
    vecs[4] = mk(8'd10,  8'd6,   1, 4'd4,  0, 5'd3,  16'h4050, 11,  54);
    vecs[5] = mk(8'd255, 8'd225, 1, 4'd15, 0, 5'd1,  16'h8000, 32,  32);
    vecs[6] = mk(8'd5,   8'd9,   0, 4'd0,  0, 5'd0,  16'h0000, 77,  77);
    vecs[7] = mk(8'd2,   8'd1,   1, 4'd1,  0, 5'd8,  16'hAAAA,  4, 144);
    vecs[8] = mk(8'd3,   8'd0,   1, 4'd0,  0, 5'd6,  16'h9249,  2, 107);
    vecs[9] = mk(8'd200, 8'd144, 1, 4'd12, 0, 5'd1,  16'h1000, 26,  33);

    // Reset, with start held to show it is ignored under reset.
    rst_n = 1'b0;
    start = 1'b1; a_in = 8'd7; r_in = 8'd2;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outputs", {done, found, root, err, root_cnt, root_mask}, 28'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven searches.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].found, vecs[i].root, vecs[i].err,
                       ALL ? vecs[i].cnt : 5'd0,
                       ALL ? vecs[i].mask : 16'd0});
      run_search(vecs[i].a, vecs[i].r, lat, b1);
      tag = $sformatf("v%0d", i);
      e = exp_q.pop_front();
      chk({tag, "_busy1"}, b1, 1'b1);
      chk({tag, "_lat"}, lat, ALL ? vecs[i].lat_all : vecs[i].lat_first);
      check_result(tag, e);
      // The following cycle is idle and results hold.
      @(negedge clk);
      chk({tag, "_idle_busy"}, {busy, done}, 2'b00);
      check_result({tag, "_hold"}, e);
    end

    // start hammered while busy and during done: first request wins.
    @(negedge clk);
    a_in = 8'd7; r_in = 8'd2; start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!done && lat < MAX_LAT) begin
      a_in = 8'd3; r_in = 8'd0; start = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("hs_done", done, 1'b1);
    chk("hs_lat", lat, ALL ? 64 : 9);
    check_result("hs", {1'b1, 4'd3, 1'b0, ALL ? 5'd4 : 5'd0,
                        ALL ? 16'h0C18 : 16'h0000});
    // start still high: ignored in DONE, accepted in the following IDLE.
    @(negedge clk);
    chk("hs_idle_after_done", busy, 1'b0);
    @(negedge clk);
    chk("hs_accept_in_idle", busy, 1'b1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
    end
    chk("hs2_lat", lat, ALL ? 107 : 2);
    check_result("hs2", {1'b1, 4'd0, 1'b0, ALL ? 5'd6 : 5'd0,
                         ALL ? 16'h9249 : 16'h0000});

    // Reset in the middle of a REDUCE run aborts without a done pulse.
    @(negedge clk);
    a_in = 8'd1; r_in = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (dut.state != REDUCE && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_in_reduce", dut.state == REDUCE, 1'b1);
    chk("mid_busy_before", busy, 1'b1);
    pulses0 = done_pulses;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_outputs", {busy, done, found, root, err, root_cnt, root_mask},
        29'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_no_done", done_pulses - pulses0, 0);
    chk("mid_stays_idle", busy, 1'b0);

    // A fresh search after the abort completes normally.
    run_search(8'd7, 8'd2, lat, b1);
    chk("post_lat", lat, ALL ? 64 : 9);
    check_result("post", {1'b1, 4'd3, 1'b0, ALL ? 5'd4 : 5'd0,
                          ALL ? 16'h0C18 : 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
